pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Program-counter / fetch-address sequencer for the UnionMagica core; sits directly upstream of the return-address stack.
- Produces the 11-bit instruction address every cycle. Resolves sequential, jump, conditional-branch, call and return flow.
- Drives the stack's in_val/store/load and consumes its out_val on return.
- Tracks stack occupancy locally so that over/underflow is trapped before it corrupts the stack.

Parameters:
- AW, 11, address width (matches stack entry width).
- STACK_DEPTH, 3, number of return-address entries in the downstream stack.
- RESET_VEC, 11'h000, first fetch address after reset.
- DW, 2, depth counter width, ceil(log2(STACK_DEPTH+1)).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- op_valid  in  1  op/target/zero_flag are valid this cycle.
- op  in  3  flow opcode: NEXT, JMP, BRZ, CALL, RET (others treated as NEXT).
- target  in  AW  jump/branch/call destination.
- zero_flag  in  1  ALU zero flag, sampled for BRZ.
- stall  in  1  hold pc and all state; no stack traffic.
- halt_req  in  1  enter HALT at next non-stalled edge.
- ret_addr_in  in  AW  stack out_val (top of stack, combinational).
- push_val  out  AW  stack in_val.
- push  out  1  stack store strobe, one cycle.
- pop  out  1  stack load strobe, one cycle.
- pc  out  AW  current fetch address.
- pc_valid  out  1  pc is a real fetch this cycle.
- depth  out  DW  number of live stack entries.
- fault  out  1  sticky over/underflow flag.
- halted  out  1  high in HALT state.

Behaviour:
- Reset (async, any time, including mid-call): state=BOOT, pc=RESET_VEC, pc_valid=0, depth=0, fault=0, halted=0, push=0, pop=0, push_val=0.
- FSM states: BOOT, RUN, HALT.
  - BOOT -> RUN after exactly one clock; pc_valid rises in the first RUN cycle with pc=RESET_VEC.
  - RUN -> HALT when halt_req=1 and stall=0; takes precedence over any op that cycle, so no push/pop occurs.
  - HALT is exited only by rst. pc frozen, pc_valid=0.
- In RUN with stall=1: pc, depth and fault hold; push=pop=0; pc_valid stays 1.
- In RUN with stall=0, next pc is selected by op when op_valid=1, else pc+1:
  - NEXT: pc+1.
  - JMP: target.
  - BRZ: target if zero_flag=1, else pc+1.
  - CALL with depth<STACK_DEPTH: pc <= target; push=1 for one cycle with push_val=pc+1; depth+1. The stack stores in_val-1, so the stored entry equals pc of the CALL.
  - CALL with depth==STACK_DEPTH: no push, pc+1, fault<=1.
  - RET with depth>0: pop=1; next pc <= ret_addr_in+1, sampled in the same cycle before the pop edge; depth-1.
  - RET with depth==0: no pop, pc+1, fault<=1.
- push and pop are registered outputs aligned with the pc update edge; they are never asserted together.
- Arithmetic is modulo 2^AW: pc+1 at 11'h7FF wraps to 11'h000 without a fault, including push_val for a CALL at 11'h7FF.
- Branch/jump latency: new pc is visible on the cycle after the op is presented; no delay slots.
- fault clears only on rst. Execution continues after a fault.

Decomposition:
- Shared package um_pkg holds:
  - op encoding constants OP_NEXT=0, OP_JMP=1, OP_BRZ=2, OP_CALL=3, OP_RET=4;
  - state encodings BOOT/RUN/HALT;
  - AW default.
- One natural sub-module, pc_next_mux: combinational next-pc/push/pop selection. The FSM, depth counter and registers stay in the top.

Test Plan:
- Reset release -> pc_valid=0 for one cycle, then pc = 0, 1, 2, 3 on consecutive edges; assert rst mid-run at pc=5 -> pc=0, depth=0 immediately (async).
- At pc=10, CALL target=0x100 -> next pc=0x100, push=1 for one cycle with push_val=11, depth=1. Then RET with ret_addr_in=10 -> pop=1, next pc=11, depth=0.
- Three nested CALLs (0x010, 0x020, 0x030), then a fourth CALL at pc=0x031 -> no push, pc=0x032, fault=1, depth=3. Three RETs unwind correctly.
- RET at depth=0 from pc=7 -> no pop, pc=8, fault=1 and stays 1 until rst.
- BRZ target=0x200 with zero_flag=0 at pc=4 -> pc=5; with zero_flag=1 -> pc=0x200. stall=1 held 3 cycles during CALL -> pc unchanged and no push until stall drops.
- pc=0x7FF with NEXT -> pc=0x000, fault=0. halt_req together with CALL -> halted=1, no push, pc frozen, pc_valid=0.

Source files
------------

// File: rtl/um_pkg.sv
// Shared definitions for the UnionMagica flow-control front end.
// Holds the flow opcode encodings, the sequencer FSM state type and
// the default address/stack geometry.
package um_pkg;

  localparam int unsigned UM_AW          = 11;
  localparam int unsigned UM_STACK_DEPTH = 3;
  localparam int unsigned UM_DW          = 2;
  localparam logic [UM_AW-1:0] UM_RESET_VEC = 11'h000;

  // Flow opcodes; any other encoding behaves as OP_NEXT.
  localparam logic [2:0] OP_NEXT = 3'd0;
  localparam logic [2:0] OP_JMP  = 3'd1;
  localparam logic [2:0] OP_BRZ  = 3'd2;
  localparam logic [2:0] OP_CALL = 3'd3;
  localparam logic [2:0] OP_RET  = 3'd4;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } seq_state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bus between the instruction-flow producer and the pc sequencer,
// including the return-address-stack side signals.
//   master : drives op/target/zero_flag/stall/halt_req/ret_addr_in
//   slave  : drives pc/pc_valid/push/pop/push_val/depth/fault/halted
interface pc_sequencer_if #(
  parameter int unsigned AW = um_pkg::UM_AW,
  parameter int unsigned DW = um_pkg::UM_DW
);

  logic          op_valid;
  logic [2:0]    op;
  logic [AW-1:0] target;
  logic          zero_flag;
  logic          stall;
  logic          halt_req;
  logic [AW-1:0] ret_addr_in;
  logic [AW-1:0] push_val;
  logic          push;
  logic          pop;
  logic [AW-1:0] pc;
  logic          pc_valid;
  logic [DW-1:0] depth;
  logic          fault;
  logic          halted;

  modport master (
    output op_valid, op, target, zero_flag, stall, halt_req, ret_addr_in,
    input  push_val, push, pop, pc, pc_valid, depth, fault, halted
  );

  modport slave (
    input  op_valid, op, target, zero_flag, stall, halt_req, ret_addr_in,
    output push_val, push, pop, pc, pc_valid, depth, fault, halted
  );

endinterface

// File: rtl/pc_next_mux.sv
// Combinational next-pc / stack-strobe selection for one RUN cycle.
// Ports: pc_i/target_i/ret_addr_i addresses, op_valid_i/op_i/zero_flag_i
// flow control, depth_i live stack entries; *_c_o are the unregistered
// next pc, push/pop strobes, push value and over/underflow indication.
module pc_next_mux
  import um_pkg::*;
#(
  parameter int unsigned AW          = UM_AW,
  parameter int unsigned DW          = UM_DW,
  parameter int unsigned STACK_DEPTH = UM_STACK_DEPTH
) (
  input  logic [AW-1:0] pc_i,
  input  logic          op_valid_i,
  input  logic [2:0]    op_i,
  input  logic [AW-1:0] target_i,
  input  logic          zero_flag_i,
  input  logic [AW-1:0] ret_addr_i,
  input  logic [DW-1:0] depth_i,
  output logic [AW-1:0] pc_next_c_o,
  output logic [AW-1:0] push_val_c_o,
  output logic          push_c_o,
  output logic          pop_c_o,
  output logic          fault_c_o
);

  logic [AW-1:0] seq_pc;

  // Modulo-2^AW increment; wrap at the top of the address space is legal.
  assign seq_pc       = pc_i + AW'(1);
  assign push_val_c_o = seq_pc;

  // Flow resolution; a missing op or unknown opcode falls through to pc+1.
  always_comb begin
    pc_next_c_o = seq_pc;
    push_c_o    = 1'b0;
    pop_c_o     = 1'b0;
    fault_c_o   = 1'b0;
    if (op_valid_i) begin
      case (op_i)
        OP_JMP: pc_next_c_o = target_i;
        OP_BRZ: begin
          if (zero_flag_i) pc_next_c_o = target_i;
        end
        OP_CALL: begin
          if (depth_i < DW'(STACK_DEPTH)) begin
            push_c_o    = 1'b1;
            pc_next_c_o = target_i;
          end else begin
            fault_c_o = 1'b1;
          end
        end
        OP_RET: begin
          // Stack holds the CALL's own pc, so resume one past it.
          if (depth_i != '0) begin
            pop_c_o     = 1'b1;
            pc_next_c_o = ret_addr_i + AW'(1);
          end else begin
            fault_c_o = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter / fetch-address sequencer feeding the return-address
// stack. Ports: clk, rst (async, active high) and bus (slave side of
// pc_sequencer_if) carrying ops in and pc/stack strobes/status out.
module pc_sequencer
  import um_pkg::*;
#(
  parameter int unsigned   AW          = UM_AW,
  parameter int unsigned   STACK_DEPTH = UM_STACK_DEPTH,
  parameter logic [AW-1:0] RESET_VEC   = AW'(UM_RESET_VEC),
  parameter int unsigned   DW          = UM_DW
) (
  input logic           clk,
  input logic           rst,
  pc_sequencer_if.slave bus
);

  seq_state_e    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] push_val_q, push_val_d;
  logic          push_q, push_d;
  logic          pop_q, pop_d;
  logic          pc_valid_q, pc_valid_d;
  logic [DW-1:0] depth_q, depth_d;
  logic          fault_q, fault_d;
  logic          halted_q, halted_d;

  logic [AW-1:0] pc_next_c;
  logic [AW-1:0] push_val_c;
  logic          push_c, pop_c, fault_c;

  pc_next_mux #(
    .AW          (AW),
    .DW          (DW),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_mux (
    .pc_i         (pc_q),
    .op_valid_i   (bus.op_valid),
    .op_i         (bus.op),
    .target_i     (bus.target),
    .zero_flag_i  (bus.zero_flag),
    .ret_addr_i   (bus.ret_addr_in),
    .depth_i      (depth_q),
    .pc_next_c_o  (pc_next_c),
    .push_val_c_o (push_val_c),
    .push_c_o     (push_c),
    .pop_c_o      (pop_c),
    .fault_c_o    (fault_c)
  );

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_VEC;
      push_val_q <= '0;
      push_q     <= 1'b0;
      pop_q      <= 1'b0;
      pc_valid_q <= 1'b0;
      depth_q    <= '0;
      fault_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      push_val_q <= push_val_d;
      push_q     <= push_d;
      pop_q      <= pop_d;
      pc_valid_q <= pc_valid_d;
      depth_q    <= depth_d;
      fault_q    <= fault_d;
      halted_q   <= halted_d;
    end
  end

  // Next-state and registered-output selection.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    push_val_d = push_val_q;
    push_d     = 1'b0;
    pop_d      = 1'b0;
    pc_valid_d = pc_valid_q;
    depth_d    = depth_q;
    fault_d    = fault_q;
    case (state_q)
      ST_BOOT: begin
        state_d    = ST_RUN;
        pc_valid_d = 1'b1;
      end
      ST_RUN: begin
        if (!bus.stall) begin
          if (bus.halt_req) begin
            // Halt wins over the op presented alongside it.
            state_d    = ST_HALT;
            pc_valid_d = 1'b0;
          end else begin
            pc_d   = pc_next_c;
            push_d = push_c;
            pop_d  = pop_c;
            if (push_c) begin
              push_val_d = push_val_c;
              depth_d    = depth_q + DW'(1);
            end
            if (pop_c) depth_d = depth_q - DW'(1);
            if (fault_c) fault_d = 1'b1;
          end
        end
      end
      ST_HALT: pc_valid_d = 1'b0;
      default: state_d = ST_BOOT;
    endcase
    halted_d = (state_d == ST_HALT);
  end

  assign bus.pc       = pc_q;
  assign bus.pc_valid = pc_valid_q;
  assign bus.push     = push_q;
  assign bus.pop      = pop_q;
  assign bus.push_val = push_val_q;
  assign bus.depth    = depth_q;
  assign bus.fault    = fault_q;
  assign bus.halted   = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed flow scenarios plus a
// randomized phase, compared every cycle against a queue-based model.
module tb_pc_sequencer;
  import um_pkg::*;

  logic clk;
  logic rst;

  pc_sequencer_if #(.AW(11), .DW(2)) bus ();

  pc_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Reference model: architectural view of the sequencer and its stack.
  logic [10:0] stk[$];
  logic [10:0] m_pc;
  logic [10:0] m_push_val;
  logic        m_valid, m_push, m_pop, m_fault, m_halted, m_boot;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    stk.delete();
    m_pc = 11'h000; m_push_val = 11'h000;
    m_valid = 0; m_push = 0; m_pop = 0; m_fault = 0; m_halted = 0; m_boot = 1;
  endtask

  task automatic model_edge(input logic v, input logic [2:0] o, input logic [10:0] t,
                            input logic z, input logic s, input logic h, input logic [10:0] ret);
    logic [10:0] seq;
    logic [2:0]  eo;
    seq = m_pc + 11'd1;
    m_push = 0;
    m_pop  = 0;
    if (m_boot) begin
      m_boot = 0;
      m_valid = 1;
    end else if (m_halted || s) begin
      // frozen
    end else if (h) begin
      m_halted = 1;
      m_valid = 0;
    end else begin
      eo = v ? o : OP_NEXT;
      if (eo == OP_JMP) m_pc = t;
      else if (eo == OP_BRZ) m_pc = z ? t : seq;
      else if (eo == OP_CALL) begin
        if (stk.size() < 3) begin
          stk.push_back(m_pc);
          m_push = 1; m_push_val = seq; m_pc = t;
        end else begin
          m_fault = 1; m_pc = seq;
        end
      end else if (eo == OP_RET) begin
        if (stk.size() > 0) begin
          void'(stk.pop_back());
          m_pop = 1; m_pc = ret + 11'd1;
        end else begin
          m_fault = 1; m_pc = seq;
        end
      end else m_pc = seq;
    end
  endtask

  // Per-cycle comparison of every registered output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc", 32'(bus.pc), 32'(m_pc));
      chk("pc_valid", 32'(bus.pc_valid), 32'(m_valid));
      chk("push", 32'(bus.push), 32'(m_push));
      chk("pop", 32'(bus.pop), 32'(m_pop));
      chk("depth", 32'(bus.depth), 32'(stk.size()));
      chk("fault", 32'(bus.fault), 32'(m_fault));
      chk("halted", 32'(bus.halted), 32'(m_halted));
      if (m_push) chk("push_val", 32'(bus.push_val), 32'(m_push_val));
      if (bus.push && bus.pop) chk("push_pop_excl", 32'(1), 32'(0));
    end
  end

  // One clock of stimulus; ret_addr_in mirrors the modelled stack top.
  task automatic step(input logic v, input logic [2:0] o, input logic [10:0] t,
                      input logic z, input logic s, input logic h);
    logic [10:0] ret;
    ret = (stk.size() > 0) ? stk[$] : 11'($urandom);
    bus.op_valid = v; bus.op = o; bus.target = t; bus.zero_flag = z;
    bus.stall = s; bus.halt_req = h; bus.ret_addr_in = ret;
    @(posedge clk);
    model_edge(v, o, t, z, s, h, ret);
    @(negedge clk);
  endtask

  task automatic nxt();                  step(1, OP_NEXT, 11'h0, 0, 0, 0); endtask
  task automatic jmp(input logic [10:0] a); step(1, OP_JMP, a, 0, 0, 0); endtask
  task automatic call(input logic [10:0] a); step(1, OP_CALL, a, 0, 0, 0); endtask
  task automatic ret_op();               step(1, OP_RET, 11'h0, 0, 0, 0); endtask

  // Async reset pulse mid-cycle, then release and pass the BOOT cycle.
  task automatic reset_pulse();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_pc", 32'(bus.pc), 32'h000);
    chk("async_rst_depth", 32'(bus.depth), 32'd0);
    chk("async_rst_valid", 32'(bus.pc_valid), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    nxt();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.op_valid = 0; bus.op = OP_NEXT; bus.target = '0; bus.zero_flag = 0;
    bus.stall = 0; bus.halt_req = 0; bus.ret_addr_in = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_pc", 32'(bus.pc), 32'h000);
    chk("rst_push_val", 32'(bus.push_val), 32'h000);
    chk("rst_halted", 32'(bus.halted), 32'd0);
    rst = 1'b0;
    chk("boot_valid", 32'(bus.pc_valid), 32'd0);
    nxt();
    chk("first_run_valid", 32'(bus.pc_valid), 32'd1);
    chk("first_run_pc", 32'(bus.pc), 32'h000);
    repeat (3) nxt();
    chk("seq_pc3", 32'(bus.pc), 32'h003);
    call(11'h005);
    chk("call_mid_depth", 32'(bus.depth), 32'd1);
    reset_pulse();

    // CALL/RET pair.
    jmp(11'h00A);
    call(11'h100);
    chk("call_pc", 32'(bus.pc), 32'h100);
    chk("call_push", 32'(bus.push), 32'd1);
    chk("call_push_val", 32'(bus.push_val), 32'h00B);
    chk("call_depth", 32'(bus.depth), 32'd1);
    ret_op();
    chk("ret_pc", 32'(bus.pc), 32'h00B);
    chk("ret_pop", 32'(bus.pop), 32'd1);
    chk("ret_depth", 32'(bus.depth), 32'd0);

    // Nested calls and overflow.
    call(11'h010); call(11'h020); call(11'h030); nxt();
    call(11'h040);
    chk("ovf_pc", 32'(bus.pc), 32'h032);
    chk("ovf_push", 32'(bus.push), 32'd0);
    chk("ovf_fault", 32'(bus.fault), 32'd1);
    chk("ovf_depth", 32'(bus.depth), 32'd3);
    ret_op(); chk("unwind1", 32'(bus.pc), 32'h021);
    ret_op(); chk("unwind2", 32'(bus.pc), 32'h011);
    ret_op(); chk("unwind3", 32'(bus.pc), 32'h00C);
    chk("unwind_depth", 32'(bus.depth), 32'd0);

    // Underflow.
    reset_pulse();
    jmp(11'h007);
    ret_op();
    chk("unf_pc", 32'(bus.pc), 32'h008);
    chk("unf_pop", 32'(bus.pop), 32'd0);
    chk("unf_fault", 32'(bus.fault), 32'd1);
    repeat (3) nxt();
    chk("fault_sticky", 32'(bus.fault), 32'd1);

    // Branches, stall, wrap.
    reset_pulse();
    jmp(11'h004); step(1, OP_BRZ, 11'h200, 0, 0, 0);
    chk("brz_nt", 32'(bus.pc), 32'h005);
    jmp(11'h004); step(1, OP_BRZ, 11'h200, 1, 0, 0);
    chk("brz_t", 32'(bus.pc), 32'h200);
    repeat (3) step(1, OP_CALL, 11'h123, 0, 1, 0);
    chk("stall_pc", 32'(bus.pc), 32'h200);
    chk("stall_push", 32'(bus.push), 32'd0);
    chk("stall_valid", 32'(bus.pc_valid), 32'd1);
    call(11'h123);
    chk("post_stall_pc", 32'(bus.pc), 32'h123);
    chk("post_stall_push_val", 32'(bus.push_val), 32'h201);
    jmp(11'h7FF); nxt();
    chk("wrap_pc", 32'(bus.pc), 32'h000);
    chk("wrap_fault", 32'(bus.fault), 32'd0);
    jmp(11'h7FF); call(11'h300);
    chk("wrap_push_val", 32'(bus.push_val), 32'h000);
    chk("wrap_call_depth", 32'(bus.depth), 32'd2);
    ret_op();
    chk("wrap_ret_pc", 32'(bus.pc), 32'h000);

    // Randomized flow.
    for (int i = 0; i < 1500; i++) begin
      logic [2:0] o;
      o = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) o = ($urandom_range(0, 1) != 0) ? OP_CALL : OP_RET;
      step(1'($urandom_range(0, 9) != 0), o, 11'($urandom), 1'($urandom),
           1'($urandom_range(0, 4) == 0), 1'b0);
    end

    // Halt: ignored while stalled, then wins over a CALL.
    jmp(11'h155);
    step(1, OP_CALL, 11'h055, 0, 1, 1);
    chk("halt_stalled", 32'(bus.halted), 32'd0);
    step(1, OP_CALL, 11'h055, 0, 0, 1);
    chk("halt_halted", 32'(bus.halted), 32'd1);
    chk("halt_push", 32'(bus.push), 32'd0);
    chk("halt_valid", 32'(bus.pc_valid), 32'd0);
    chk("halt_pc", 32'(bus.pc), 32'h155);
    repeat (3) call(11'h066);
    chk("halt_frozen_pc", 32'(bus.pc), 32'h155);
    chk("halt_still", 32'(bus.halted), 32'd1);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
